// File: rtl/life_gen_ctrl_if.sv
// Row-serial pattern load channel between a loader (master) and life_gen_ctrl (slave).
interface life_gen_ctrl_if #(
  parameter int COLS = 16
);
  logic            load_start;
  logic            load_valid;
  logic            load_ready;
  logic [COLS-1:0] load_row_data;

  modport master (output load_start, output load_valid, output load_row_data, input load_ready);
  modport slave  (input load_start, input load_valid, input load_row_data, output load_ready);
endinterface

// File: rtl/life_gen_ctrl.sv
// Generation controller for a Game of Life grid: owns the cell register, loads rows, steps/runs.
// Optional LIFE_AUTO_HALT_EN: a stable grid ends RUN at its tick until run is re-asserted.
module life_gen_ctrl #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  life_gen_ctrl_if.slave       ld,
  input  logic                 run,
  input  logic                 step,
  input  logic [ROWS*COLS-1:0] grid_evolve,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     generation,
  output logic                 busy,
  output logic                 extinct,
  output logic                 stable
);
  localparam int CELLS = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW    = $clog2(TICK_DIV);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GEN_W-1:0] GEN_ONE   = GEN_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t           state_r, state_n;
  logic [CELLS-1:0] grid_r, grid_n;
  logic [GEN_W-1:0] gen_r, gen_n;
  logic [RW-1:0]    row_cnt_r, row_cnt_n;
  logic [TW-1:0]    tick_cnt_r, tick_cnt_n;
`ifdef LIFE_AUTO_HALT_EN
  // Set when RUN halted on a still life; cleared once run drops, so only a fresh rise re-enters.
  logic             halt_hold_r, halt_hold_n;
`endif

  // State, grid, counters register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      grid_r     <= {CELLS{1'b0}};
      gen_r      <= {GEN_W{1'b0}};
      row_cnt_r  <= {RW{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
`ifdef LIFE_AUTO_HALT_EN
      halt_hold_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_n;
      grid_r     <= grid_n;
      gen_r      <= gen_n;
      row_cnt_r  <= row_cnt_n;
      tick_cnt_r <= tick_cnt_n;
`ifdef LIFE_AUTO_HALT_EN
      halt_hold_r <= halt_hold_n;
`endif
    end
  end

  // Next-state and datapath capture decisions
  always_comb begin
    state_n    = state_r;
    grid_n     = grid_r;
    gen_n      = gen_r;
    row_cnt_n  = row_cnt_r;
    tick_cnt_n = tick_cnt_r;
`ifdef LIFE_AUTO_HALT_EN
    halt_hold_n = halt_hold_r & run;
`endif
    case (state_r)
      IDLE: begin
        if (ld.load_start) begin
          state_n   = LOAD;
          row_cnt_n = {RW{1'b0}};
        end else if (step) begin
          grid_n = grid_evolve;
          gen_n  = gen_r + GEN_ONE;
`ifdef LIFE_AUTO_HALT_EN
        end else if (run && !halt_hold_r) begin
`else
        end else if (run) begin
`endif
          state_n    = RUN;
          tick_cnt_n = {TW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        // A restart wins over the row presented in the same cycle.
        if (ld.load_start) begin
          row_cnt_n = {RW{1'b0}};
        end else if (ld.load_valid) begin
          grid_n[int'(row_cnt_r)*COLS +: COLS] = ld.load_row_data;
          if (row_cnt_r == ROW_LAST) begin
            state_n   = IDLE;
            gen_n     = {GEN_W{1'b0}};
            row_cnt_n = {RW{1'b0}};
          end else begin
            row_cnt_n = row_cnt_r + RW'(1);
          end
        end else begin
          row_cnt_n = row_cnt_r;
        end
      end
      RUN: begin
        if (ld.load_start) begin
          state_n    = LOAD;
          row_cnt_n  = {RW{1'b0}};
          tick_cnt_n = {TW{1'b0}};
        end else if (!run) begin
          state_n    = IDLE;
          tick_cnt_n = {TW{1'b0}};
        end else if (tick_cnt_r == TICK_LAST) begin
          tick_cnt_n = {TW{1'b0}};
`ifdef LIFE_AUTO_HALT_EN
          if (stable) begin
            state_n     = IDLE;
            halt_hold_n = 1'b1;
          end else begin
            grid_n = grid_evolve;
            gen_n  = gen_r + GEN_ONE;
          end
`else
          grid_n = grid_evolve;
          gen_n  = gen_r + GEN_ONE;
`endif
        end else begin
          tick_cnt_n = tick_cnt_r + TW'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        tick_cnt_n = {TW{1'b0}};
        row_cnt_n  = {RW{1'b0}};
      end
    endcase
  end

  assign grid          = grid_r;
  assign generation    = gen_r;
  assign busy          = (state_r != IDLE);
  assign ld.load_ready = (state_r == LOAD);
  assign extinct       = (grid_r == {CELLS{1'b0}});
  assign stable        = (grid_evolve == grid_r);
endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl on an 8x8 grid with a bounded-plane Life model as datapath.
module tb_life_gen_ctrl;
  localparam int R = 8;
  localparam int C = 8;
  localparam logic [63:0] BLINK_H = 64'h0000_001C_0000_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0808_0800_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [63:0] grid_evolve;
  logic [63:0] grid;
  logic [1:0]  generation;
  logic        busy, extinct, stable;
  int          total = 0;
  int          bad = 0;

  life_gen_ctrl_if #(.COLS(C)) lif ();

  life_gen_ctrl #(.ROWS(R), .COLS(C), .TICK_DIV(4), .GEN_W(2)) dut (
    .clk(clk), .reset(reset), .ld(lif.slave), .run(run), .step(step),
    .grid_evolve(grid_evolve), .grid(grid), .generation(generation),
    .busy(busy), .extinct(extinct), .stable(stable)
  );

  always #5 clk = ~clk;

  // Conway rule, cells outside the 8x8 plane count as dead
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = 64'h0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < R && c+dc >= 0 && c+dc < C)
              cnt += int'(g[(r+dr)*C + c+dc]);
        n[r*C+c] = (cnt == 3) || (g[r*C+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign grid_evolve = life_next(grid);

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic load_pattern(input logic [63:0] pat);
    lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    lif.load_valid = 1'b1;
    for (int r = 0; r < R; r++) begin
      lif.load_row_data = pat[r*C +: C];
      tick();
    end
    lif.load_valid = 1'b0;
  endtask

  initial begin
    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_row_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_val("rst_grid", grid, 64'h0);
    check_val("rst_gen", 64'(generation), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ready", 64'(lif.load_ready), 64'd0);
    check_val("rst_extinct", 64'(extinct), 64'd1);
    check_val("rst_stable", 64'(stable), 64'd1);

    pulse_step();
    check_val("step_empty_gen", 64'(generation), 64'd1);

    // Gapped load with a restart after row 2
    lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    check_val("load_busy", 64'(busy), 64'd1);
    for (int r = 0; r < 3; r++) begin
      lif.load_valid = 1'b1;
      lif.load_row_data = 8'h81;
      check_val("load_ready_pre", 64'(lif.load_ready), 64'd1);
      tick();
      lif.load_valid = 1'b0;
      tick();
    end
    lif.load_start = 1'b1;
    lif.load_valid = 1'b1;
    lif.load_row_data = 8'hFF;
    tick();
    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    check_val("restart_nowrite", grid, 64'h0000_0000_0081_8181);
    for (int r = 0; r < R; r++) begin
      lif.load_valid = 1'b1;
      lif.load_row_data = BLINK_H[r*C +: C];
      check_val("load_ready_row", 64'(lif.load_ready), 64'd1);
      tick();
      lif.load_valid = 1'b0;
      if (r == 3) check_val("partial_keep", grid, 64'h0000_0000_0000_0000);
      if (r < R-1) tick();
    end
    check_val("load_done_ready", 64'(lif.load_ready), 64'd0);
    check_val("load_done_busy", 64'(busy), 64'd0);
    check_val("load_done_gen", 64'(generation), 64'd0);
    check_val("load_done_grid", grid, BLINK_H);
    check_val("blink_extinct", 64'(extinct), 64'd0);
    check_val("blink_stable", 64'(stable), 64'd0);

    pulse_step();
    check_val("step1_grid", grid, BLINK_V);
    check_val("step1_gen", 64'(generation), 64'd1);
    pulse_step();
    check_val("step2_grid", grid, BLINK_H);
    check_val("step2_gen", 64'(generation), 64'd2);

    // RUN: updates 4, 8, 12 cycles after entry
    run = 1'b1;
    tick();
    check_val("run_entry_busy", 64'(busy), 64'd1);
    check_val("run_entry_gen", 64'(generation), 64'd2);
    for (int c = 1; c <= 15; c++) begin
      tick();
      check_val("run_gen", 64'(generation), 64'((2 + c/4) % 4));
    end
    run = 1'b0;
    tick();
    check_val("run_drop_busy", 64'(busy), 64'd0);
    check_val("run_drop_gen", 64'(generation), 64'd1);
    check_val("run_drop_grid", grid, BLINK_V);

    // Still life under RUN
    load_pattern(BLOCK);
    check_val("block_grid", grid, BLOCK);
    check_val("block_stable", 64'(stable), 64'd1);
    check_val("block_extinct", 64'(extinct), 64'd0);
    run = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) tick();
`ifdef LIFE_AUTO_HALT_EN
    check_val("halt_busy", 64'(busy), 64'd0);
    check_val("halt_gen", 64'(generation), 64'd0);
    for (int c = 0; c < 4; c++) tick();
    check_val("halt_hold_busy", 64'(busy), 64'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check_val("halt_reenter_busy", 64'(busy), 64'd1);
`else
    check_val("norun_halt_busy", 64'(busy), 64'd1);
    check_val("norun_halt_gen1", 64'(generation), 64'd1);
    for (int c = 0; c < 4; c++) tick();
    check_val("norun_halt_gen2", 64'(generation), 64'd2);
`endif
    run = 1'b0;
    tick();
    check_val("block_idle", 64'(busy), 64'd0);

    // Counter wrap
    load_pattern(BLOCK);
    check_val("wrap_gen0", 64'(generation), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      pulse_step();
      check_val("wrap_gen", 64'(generation), 64'(k % 4));
    end
    pulse_step();
    check_val("prio_pre_gen", 64'(generation), 64'd1);

    // load_start beats step; step and run ignored in LOAD
    lif.load_start = 1'b1;
    step = 1'b1;
    tick();
    lif.load_start = 1'b0;
    check_val("prio_ready", 64'(lif.load_ready), 64'd1);
    check_val("prio_gen", 64'(generation), 64'd1);
    run = 1'b1;
    tick();
    step = 1'b0;
    run = 1'b0;
    check_val("load_ign_gen", 64'(generation), 64'd1);
    check_val("load_ign_ready", 64'(lif.load_ready), 64'd1);
    lif.load_valid = 1'b1;
    for (int r = 0; r < R; r++) begin
      lif.load_row_data = BLINK_H[r*C +: C];
      tick();
    end
    lif.load_valid = 1'b0;
    check_val("reload_grid", grid, BLINK_H);
    pulse_step();

    // Asynchronous reset in the middle of RUN
    run = 1'b1;
    tick();
    tick();
    tick();
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    check_val("pre_rst_gen", 64'(generation), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_grid", grid, 64'h0);
    check_val("arst_gen", 64'(generation), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_ready", 64'(lif.load_ready), 64'd0);
    check_val("arst_extinct", 64'(extinct), 64'd1);
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_val("post_rst_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
